// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
// Shares one external combinational ALU between two requesters.
// A request is accepted in IDLE (round-robin between simultaneous requesters).
// Its operands are registered onto alu_a/alu_b/alu_sel, and the ALU result is
// captured one cycle later into that requester's response registers. The
// response is then held until the requester handshakes it. Illegal op codes
// skip the ALU and return an error response straight away.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   reqN_valid/ready              request handshake for requester N (0/1)
//   reqN_a, reqN_b, reqN_op       request operands and op select
//   rspN_valid/ready              response handshake for requester N
//   rspN_data/zero/carry/err      result, ALU flags and illegal-op flag
//   alu_a, alu_b, alu_sel         registered operands/op driven to the ALU
//   alu_out, alu_zero, alu_carry  combinational ALU result and flags
//   busy                          a transaction is in flight
module alu_share_arbiter #(
  parameter int DATA_W = 4,
  parameter int OP_W   = 5,
  parameter int OUT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [OP_W-1:0]   req0_op,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [OUT_W-1:0]  rsp0_data,
  output logic              rsp0_zero,
  output logic              rsp0_carry,
  output logic              rsp0_err,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [OP_W-1:0]   req1_op,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [OUT_W-1:0]  rsp1_data,
  output logic              rsp1_zero,
  output logic              rsp1_carry,
  output logic              rsp1_err,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_sel,
  input  logic [OUT_W-1:0]  alu_out,
  input  logic              alu_zero,
  input  logic              alu_carry,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t state, state_nxt;
  logic   rr_ptr;
  logic   owner;

  logic              grant;
  logic              accept;
  logic              acc_legal;
  logic              rsp_done;
  logic [DATA_W-1:0] acc_a;
  logic [DATA_W-1:0] acc_b;
  logic [OP_W-1:0]   acc_op;

  // Low three op bits select the function; codes 6 and 7 are undefined.
  function automatic logic op_legal(input logic [OP_W-1:0] op);
    return op[2:0] <= 3'd5;
  endfunction

  // Round-robin only matters when both requesters are valid.
  always_comb begin
    grant      = (req0_valid && req1_valid) ? rr_ptr : req1_valid;
    req0_ready = (state == IDLE) && req0_valid && !grant;
    req1_ready = (state == IDLE) && req1_valid && grant;
    accept     = req0_ready || req1_ready;
    acc_a      = grant ? req1_a  : req0_a;
    acc_b      = grant ? req1_b  : req0_b;
    acc_op     = grant ? req1_op : req0_op;
    acc_legal  = op_legal(acc_op);
    rsp_done   = (state == RESP) &&
                 (owner ? (rsp1_valid && rsp1_ready) : (rsp0_valid && rsp0_ready));
    busy       = (state != IDLE);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = acc_legal ? EXEC : RESP;
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rr_ptr     <= 1'b0;
      owner      <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_sel    <= '0;
      rsp0_valid <= 1'b0;
      rsp0_data  <= '0;
      rsp0_zero  <= 1'b0;
      rsp0_carry <= 1'b0;
      rsp0_err   <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp1_data  <= '0;
      rsp1_zero  <= 1'b0;
      rsp1_carry <= 1'b0;
      rsp1_err   <= 1'b0;
    end else begin
      state <= state_nxt;
      // Accept: a legal op is staged onto the ALU; an illegal op bypasses it
      // and leaves the ALU registers holding the last legal op.
      if (accept) begin
        owner <= grant;
        if (acc_legal) begin
          alu_a   <= acc_a;
          alu_b   <= acc_b;
          alu_sel <= acc_op;
        end else if (grant) begin
          rsp1_valid <= 1'b1;
          rsp1_data  <= '0;
          rsp1_zero  <= 1'b0;
          rsp1_carry <= 1'b0;
          rsp1_err   <= 1'b1;
        end else begin
          rsp0_valid <= 1'b1;
          rsp0_data  <= '0;
          rsp0_zero  <= 1'b0;
          rsp0_carry <= 1'b0;
          rsp0_err   <= 1'b1;
        end
      end
      // Execute: ALU output has settled from the staged operands.
      if (state == EXEC) begin
        if (owner) begin
          rsp1_valid <= 1'b1;
          rsp1_data  <= alu_out;
          rsp1_zero  <= alu_zero;
          rsp1_carry <= alu_carry;
          rsp1_err   <= 1'b0;
        end else begin
          rsp0_valid <= 1'b1;
          rsp0_data  <= alu_out;
          rsp0_zero  <= alu_zero;
          rsp0_carry <= alu_carry;
          rsp0_err   <= 1'b0;
        end
      end
      // Response: priority passes to the other requester once this one is served.
      if (rsp_done) begin
        rr_ptr <= ~owner;
        if (owner) rsp1_valid <= 1'b0;
        else       rsp0_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Testbench for alu_share_arbiter: a behavioural ALU drives the ALU inputs, and
// a transaction-level model predicts grants, latencies and responses.
module tb_alu_share_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req0_ready, rsp0_valid, rsp0_ready;
  logic [3:0] req0_a, req0_b;
  logic [4:0] req0_op;
  logic [7:0] rsp0_data;
  logic       rsp0_zero, rsp0_carry, rsp0_err;
  logic       req1_valid, req1_ready, rsp1_valid, rsp1_ready;
  logic [3:0] req1_a, req1_b;
  logic [4:0] req1_op;
  logic [7:0] rsp1_data;
  logic       rsp1_zero, rsp1_carry, rsp1_err;
  logic [3:0] alu_a, alu_b;
  logic [4:0] alu_sel;
  logic [7:0] alu_out;
  logic       alu_zero, alu_carry, busy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  alu_share_arbiter #(.DATA_W(4), .OP_W(5), .OUT_W(8)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a),
    .req0_b(req0_b), .req0_op(req0_op),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
    .rsp0_zero(rsp0_zero), .rsp0_carry(rsp0_carry), .rsp0_err(rsp0_err),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a),
    .req1_b(req1_b), .req1_op(req1_op),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
    .rsp1_zero(rsp1_zero), .rsp1_carry(rsp1_carry), .rsp1_err(rsp1_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_out(alu_out), .alu_zero(alu_zero), .alu_carry(alu_carry),
    .busy(busy)
  );

  // ALU: 0 add, 1 sub (carry = borrow), 2 mul, 3 and, 4 or, 5 xor.
  // Returns {carry, zero, result}.
  function automatic logic [9:0] alu_fn(input logic [3:0] a, input logic [3:0] b,
                                        input logic [4:0] op);
    logic [7:0] o;
    logic       c;
    logic [4:0] t;
    o = '0;
    c = 1'b0;
    t = '0;
    case (op[2:0])
      3'd0: begin t = {1'b0, a} + {1'b0, b}; o = {4'b0, t[3:0]}; c = t[4]; end
      3'd1: begin t = {1'b0, a} - {1'b0, b}; o = {4'b0, t[3:0]}; c = t[4]; end
      3'd2: o = {4'b0, a} * {4'b0, b};
      3'd3: o = {4'b0, a & b};
      3'd4: o = {4'b0, a | b};
      3'd5: o = {4'b0, a ^ b};
      default: o = '0;
    endcase
    return {c, (o == 8'd0), o};
  endfunction

  always_comb begin
    {alu_carry, alu_zero, alu_out} = alu_fn(alu_a, alu_b, alu_sel);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Transaction-level reference state
  int         cyc = 0;
  bit         pend = 0;
  bit         m_owner, m_rr = 0;
  int         m_due;
  logic [7:0] m_data;
  bit         m_zero, m_carry, m_err;
  logic [3:0] m_a = 0, m_b = 0;
  logic [4:0] m_sel = 0;

  // One clock cycle: apply inputs, check at negedge, advance the model at posedge.
  task automatic step(input bit r, input bit v0, input logic [3:0] a0, input logic [3:0] b0,
                      input logic [4:0] op0, input bit v1, input logic [3:0] a1,
                      input logic [3:0] b1, input logic [4:0] op1,
                      input bit rr0, input bit rr1);
    bit         g, er0, er1, rv;
    logic [9:0] res;
    logic [3:0] sa, sb;
    logic [4:0] sop;
    rst = r;
    req0_valid = v0; req0_a = a0; req0_b = b0; req0_op = op0;
    req1_valid = v1; req1_a = a1; req1_b = b1; req1_op = op1;
    rsp0_ready = rr0; rsp1_ready = rr1;
    @(negedge clk);
    g   = (v0 && v1) ? m_rr : v1;
    er0 = !pend && v0 && !g;
    er1 = !pend && v1 && g;
    rv  = pend && (cyc >= m_due);
    chk("req0_ready", req0_ready, er0);
    chk("req1_ready", req1_ready, er1);
    chk("busy", busy, pend);
    chk("rsp0_valid", rsp0_valid, rv && !m_owner);
    chk("rsp1_valid", rsp1_valid, rv && m_owner);
    if (rv) begin
      chk("rsp_data", m_owner ? rsp1_data : rsp0_data, m_data);
      chk("rsp_zero", m_owner ? rsp1_zero : rsp0_zero, m_zero);
      chk("rsp_carry", m_owner ? rsp1_carry : rsp0_carry, m_carry);
      chk("rsp_err", m_owner ? rsp1_err : rsp0_err, m_err);
    end
    chk("alu_a", alu_a, m_a);
    chk("alu_b", alu_b, m_b);
    chk("alu_sel", alu_sel, m_sel);
    @(posedge clk);
    if (r) begin
      pend = 0; m_rr = 0; m_a = 0; m_b = 0; m_sel = 0;
    end else if (rv && (m_owner ? rr1 : rr0)) begin
      pend = 0;
      m_rr = !m_owner;
    end else if (!pend && (v0 || v1)) begin
      pend    = 1;
      m_owner = g;
      sa  = g ? a1 : a0;
      sb  = g ? b1 : b0;
      sop = g ? op1 : op0;
      if (sop[2:0] <= 3'd5) begin
        res = alu_fn(sa, sb, sop);
        {m_carry, m_zero, m_data} = res;
        m_err = 0;
        m_due = cyc + 2;
        m_a = sa; m_b = sb; m_sel = sop;
      end else begin
        m_data = 0; m_zero = 0; m_carry = 0; m_err = 1;
        m_due = cyc + 1;
      end
    end
    cyc++;
    #1;
  endtask

  task automatic idle(input int n, input bit rr0, input bit rr1);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, rr0, rr1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1;
    req0_valid = 0; req0_a = 0; req0_b = 0; req0_op = 0; rsp0_ready = 0;
    req1_valid = 0; req1_a = 0; req1_b = 0; req1_op = 0; rsp1_ready = 0;
    repeat (3) @(posedge clk);
    #1;
    // Reset values
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("rst_rsp0_data", rsp0_data, 0);
    chk("rst_rsp1_data", rsp1_data, 0);
    chk("rst_flags", {rsp0_zero, rsp0_carry, rsp0_err, rsp1_zero, rsp1_carry, rsp1_err}, 0);
    @(posedge clk);
    cyc++;
    #1;
    idle(1, 0, 0);

    // Single op: 5+3
    step(0, 1, 5, 3, 5'b00000, 0, 0, 0, 0, 1, 1);
    idle(4, 1, 1);

    // Contention after reset, then fairness over many ops
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++)
      step(0, 1, 7, 2, 5'b00010, 1, 4, 4, 5'b00001, 1, 1);
    idle(3, 1, 1);

    // Backpressure on requester 1 while requester 0 keeps asking
    step(0, 0, 0, 0, 0, 1, 5, 3, 5'b10011, 0, 0);
    for (int i = 0; i < 6; i++)
      step(0, 1, 1, 1, 5'b00000, 1, 9, 9, 5'b11111, 0, 0);
    step(0, 1, 1, 1, 5'b00000, 0, 0, 0, 0, 0, 1);
    idle(5, 1, 1);

    // Illegal op keeps alu_* unchanged
    step(0, 1, 9, 9, 5'b00110, 0, 0, 0, 0, 1, 1);
    idle(3, 1, 1);
    step(0, 0, 0, 0, 0, 1, 2, 2, 5'b11111, 1, 1);
    idle(3, 1, 1);

    // Reset in the EXEC cycle
    step(0, 1, 3, 4, 5'b00000, 0, 0, 0, 0, 1, 1);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    idle(3, 1, 1);
    step(0, 1, 6, 6, 5'b01101, 1, 2, 3, 5'b00100, 1, 1);
    idle(4, 1, 1);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      step(($urandom_range(0, 299) == 0),
           ($urandom_range(0, 9) < 6), 4'($urandom), 4'($urandom), 5'($urandom),
           ($urandom_range(0, 9) < 6), 4'($urandom), 4'($urandom), 5'($urandom),
           ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 7));
    end
    idle(5, 1, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
